fp16_acc_seq: RTL and testbench

- Accumulation sequencer for the fp16 MAC datapath.
- Sits between the product stream (multiplier output) and the registered fp16 adder.
- Takes a run of `len` fp16 products over a valid/ready handshake and drives the adder's A/B operands, feeding the adder's registered sum back as the running total.
- Presents the final fp16 sum on a valid/ready output.

---
 rtl/fp16_mac_pkg.sv | 16 +
 rtl/fp16_acc_cnt.sv | 28 ++
 rtl/fp16_acc_seq.sv | 129 ++++++++++++
 tb/tb_fp16_acc_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_mac_pkg.sv
// Shared definitions for the fp16 MAC datapath: operand width, the fp16 zero
// pattern, adder latency and the accumulation sequencer state encoding.
package fp16_mac_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
    localparam int ADD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp16_acc_cnt.sv
// Loadable down-counter holding the number of terms still to be accepted in
// the current run. last flags the final term (count == 1).
module fp16_acc_cnt #(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic [LEN_W-1:0] count,
    output logic             last
);

    // Load wins over decrement; never wrap below zero.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == LEN_W'(1));

endmodule

// File: rtl/fp16_acc_seq.sv
// Accumulation sequencer between the fp16 product stream and the registered
// fp16 adder. Feeds each accepted product to operand B and the adder's own
// registered sum back to operand A, then presents the final total.
// Optional feature macro: FP16_ACC_ABORT_EN adds an abort input that drops an
// in-progress run (ACC or DRAIN) back to IDLE without producing a result.
//
// Handshakes: a transfer happens on a rising CLK edge where both valid and
// ready are high. in_ready depends only on state (and abort), never on
// in_valid; out_valid stays high and out_data stays stable until out_ready.
module fp16_acc_seq
    import fp16_mac_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [FP16_W-1:0] in_data,
    output logic              in_ready,
    output logic [FP16_W-1:0] add_a,
    output logic [FP16_W-1:0] add_b,
    input  logic [FP16_W-1:0] add_sum,
    output logic              out_valid,
    output logic [FP16_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output state_t            fsm_state
`ifdef FP16_ACC_ABORT_EN
    ,
    input  logic              abort
`endif
);

    state_t     state;
    state_t     state_nxt;
    logic       first;
    logic       abort_hit;
    logic       accept;
    logic       cnt_load;
    logic       cnt_last;
    logic [LEN_W-1:0] cnt_count;

`ifdef FP16_ACC_ABORT_EN
    assign abort_hit = abort && ((state == ACC) || (state == DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    assign accept   = in_valid && in_ready;
    assign cnt_load = (state == IDLE) && start && (len != '0);

    fp16_acc_cnt #(.LEN_W(LEN_W)) u_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (cnt_load),
        .load_val (len),
        .dec      (accept),
        .count    (cnt_count),
        .last     (cnt_last)
    );

    // State register plus first-term flag and result register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            first    <= 1'b1;
            out_data <= FP16_ZERO;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start) begin
                first <= 1'b1;
                if (len == '0) begin
                    out_data <= FP16_ZERO;
                end
            end
            if (accept) begin
                first <= 1'b0;
            end
            // The adder's sum registered on the last-accept edge is final here.
            if ((state == DRAIN) && !abort_hit) begin
                out_data <= add_sum;
            end
        end
    end

    // Next-state and operand/handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        add_a     = FP16_ZERO;
        add_b     = FP16_ZERO;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                if (abort_hit) begin
                    state_nxt = IDLE;
                end else begin
                    in_ready = 1'b1;
                    // Bubbles feed zero on B, so the adder simply returns A.
                    add_a    = first ? FP16_ZERO : add_sum;
                    add_b    = in_valid ? in_data : FP16_ZERO;
                    if (accept && cnt_last) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nxt = abort_hit ? IDLE : DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_fp16_acc_seq.sv
// Bench for fp16_acc_seq: directed runs from the plan plus randomized runs of
// small integer-valued fp16 terms, with a behavioural fp16 adder model in the
// feedback path and a scoreboard of expected results.
module tb_fp16_acc_seq;
  import fp16_mac_pkg::*;

  localparam int LEN_W = 8;

  logic              CLK;
  logic              RESET;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              in_ready;
  logic [15:0]       add_a;
  logic [15:0]       add_b;
  logic [15:0]       add_sum;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              out_ready;
  logic              busy;
  state_t            fsm_state;
`ifdef FP16_ACC_ABORT_EN
  logic              abort;
`endif

  int n_cmp;
  int n_err;
  logic [15:0] exp_q[$];
  logic [15:0] terms[0:15];

  fp16_acc_seq #(.LEN_W(LEN_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .fsm_state (fsm_state)
`ifdef FP16_ACC_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- fp16 helpers (exact for |v| < 2048) ----------------
  function automatic logic [15:0] int_to_fp16(input int v);
    int m;
    int e;
    logic s;
    if (v == 0) return 16'h0000;
    s = (v < 0);
    m = s ? -v : v;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    return {s, 5'(e + 15), 10'((m << (10 - e)) & 1023)};
  endfunction

  function automatic int fp16_to_int(input logic [15:0] h);
    int e;
    int m;
    int v;
    if (h[14:0] == 15'd0) return 0;
    e = int'(h[14:10]) - 15;
    m = 1024 | int'(h[9:0]);
    v = (e >= 10) ? (m << (e - 10)) : (m >> (10 - e));
    return h[15] ? -v : v;
  endfunction

  function automatic logic is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    if (is_nan(a) || is_nan(b)) return 16'h7C01;
    if (b == 16'h0000) return a;
    return int_to_fp16(fp16_to_int(a) + fp16_to_int(b));
  endfunction

  // Registered adder model, one cycle from operands to sum.
  initial add_sum = 16'h0000;
  always @(posedge CLK) add_sum <= fadd(add_a, add_b);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every output handshake must match the oldest expected result.
  always @(negedge CLK) begin
    if (!RESET && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 16'd1, 16'd0);
      end else begin
        check("sb_result", out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One complete run of n terms from terms[], with up to max_bub idle cycles
  // before each term. chk_part enables running-total checks during bubbles.
  task automatic do_run(input int n, input int max_bub, input logic chk_part,
                        input logic [15:0] exp);
    int part;
    int bub;
    int hold;
    exp_q.push_back(exp);
    check("idle_before_start", 16'(fsm_state), 16'(IDLE));
    start = 1'b1;
    len   = LEN_W'(n);
    step();
    start = 1'b0;
    len   = LEN_W'($urandom_range(0, 255));
    part  = 0;
    if (n == 0) begin
      check("len0_in_ready", 16'(in_ready), 16'd0);
    end
    for (int i = 0; i < n; i++) begin
      bub = $urandom_range(0, max_bub);
      for (int k = 0; k < bub; k++) begin
        in_valid = 1'b0;
        in_data  = 16'(($urandom_range(0, 65535)));
        #1;
        check("bubble_in_ready", 16'(in_ready), 16'd1);
        check("bubble_add_b", add_b, 16'h0000);
        if (chk_part) check("bubble_add_a", add_a, (i == 0) ? 16'h0000 : int_to_fp16(part));
        step();
      end
      in_valid = 1'b1;
      in_data  = terms[i];
      #1;
      check("term_in_ready", 16'(in_ready), 16'd1);
      check("term_add_b", add_b, terms[i]);
      if (chk_part) check("term_add_a", add_a, (i == 0) ? 16'h0000 : int_to_fp16(part));
      part += fp16_to_int(terms[i]);
      step();
      in_valid = 1'b0;
    end
    if (n != 0) begin
      // One cycle after the last accept: result not yet valid.
      check("drain_out_valid", 16'(out_valid), 16'd0);
      check("drain_in_ready", 16'(in_ready), 16'd0);
      step();
    end
    check("done_out_valid", 16'(out_valid), 16'd1);
    check("done_out_data", out_data, exp);
    check("done_in_ready", 16'(in_ready), 16'd0);
    hold = $urandom_range(0, 3);
    for (int k = 0; k < hold; k++) begin
      start = 1'($urandom_range(0, 1));
      len   = LEN_W'($urandom_range(0, 255));
      step();
      check("hold_out_valid", 16'(out_valid), 16'd1);
      check("hold_out_data", out_data, exp);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_out_valid", 16'(out_valid), 16'd0);
    check("post_busy", 16'(busy), 16'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int sum;
    int v;
    n_cmp     = 0;
    n_err     = 0;
    RESET     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
`ifdef FP16_ACC_ABORT_EN
    abort     = 1'b0;
`endif
    step();
    step();
    check("rst_state", 16'(fsm_state), 16'(IDLE));
    check("rst_in_ready", 16'(in_ready), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_add_a", add_a, 16'h0000);
    check("rst_add_b", add_b, 16'h0000);
    check("rst_busy", 16'(busy), 16'd0);
    RESET = 1'b0;
    step();

    // 1 + 2 + 3 = 6, back to back then with 2-cycle bubbles.
    terms[0] = 16'h3C00; terms[1] = 16'h4000; terms[2] = 16'h4200;
    do_run(3, 0, 1'b1, 16'h4600);
    do_run(3, 2, 1'b1, 16'h4600);
    // Empty run.
    do_run(0, 0, 1'b0, 16'h0000);
    // 4 + (-2) = 2.
    terms[0] = 16'h4400; terms[1] = 16'hC000;
    do_run(2, 0, 1'b1, 16'h4000);
    // NaN passes through from the adder.
    terms[0] = 16'h3C00; terms[1] = 16'h7E00;
    do_run(2, 0, 1'b0, 16'h7C01);

    // Reset in the middle of a run discards it.
    start = 1'b1;
    len   = LEN_W'(3);
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h4000;
    step();
    in_valid = 1'b0;
    RESET    = 1'b1;
    step();
    RESET = 1'b0;
    check("midrst_state", 16'(fsm_state), 16'(IDLE));
    check("midrst_in_ready", 16'(in_ready), 16'd0);
    check("midrst_out_valid", 16'(out_valid), 16'd0);
    check("midrst_out_data", out_data, 16'h0000);
    check("midrst_add_a", add_a, 16'h0000);
    check("midrst_add_b", add_b, 16'h0000);
    check("midrst_busy", 16'(busy), 16'd0);
    terms[0] = 16'h3C00;
    do_run(1, 1, 1'b1, 16'h3C00);

`ifdef FP16_ACC_ABORT_EN
    // Abort after one term: no result, straight back to IDLE.
    start = 1'b1;
    len   = LEN_W'(3);
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h4000;
    step();
    abort = 1'b1;
    #1;
    check("abort_in_ready", 16'(in_ready), 16'd0);
    check("abort_add_a", add_a, 16'h0000);
    check("abort_add_b", add_b, 16'h0000);
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_state", 16'(fsm_state), 16'(IDLE));
    check("abort_out_valid", 16'(out_valid), 16'd0);
    step();
    check("abort_quiet", 16'(out_valid), 16'd0);
    terms[0] = 16'h4000;
    do_run(1, 0, 1'b1, 16'h4000);
`endif

    // Randomized runs of small integer terms against the arithmetic sum.
    for (int r = 0; r < 12; r++) begin
      n   = $urandom_range(1, 12);
      sum = 0;
      for (int i = 0; i < n; i++) begin
        v        = int'($urandom_range(0, 16)) - 8;
        terms[i] = int_to_fp16(v);
        sum     += v;
      end
      do_run(n, 2, 1'b1, int_to_fp16(sum));
    end

    step();
    check("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
